// File: rtl/riscv_defines_pkg.sv
// Shared types for the load/store path: memory access command, LSU fault codes,
// LSU state encoding, funct3 constants and the request legality check.
package riscv_defines;

    typedef enum logic [1:0] {
        MEM_DISABLED = 2'd0,
        MEM_READ     = 2'd1,
        MEM_WRITE    = 2'd2
    } memaccess_t;

    typedef enum logic [1:0] {
        LSU_OK       = 2'd0,
        LSU_MISALIGN = 2'd1,
        LSU_ACCESS   = 2'd2,
        LSU_ILLEGAL  = 2'd3
    } lsu_fault_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FAULT = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Illegal size/sign encodings win over misalignment.
    function automatic lsu_fault_t lsu_check(input logic store,
                                             input logic [2:0] funct3,
                                             input logic [1:0] addr_lo);
        lsu_fault_t fault;
        fault = LSU_OK;
        case (funct3)
            F3_B:  fault = LSU_OK;
            F3_H:  if (addr_lo[0]) fault = LSU_MISALIGN;
            F3_W:  if (addr_lo != 2'b00) fault = LSU_MISALIGN;
            F3_BU: if (store) fault = LSU_ILLEGAL;
            F3_HU: begin
                if (store)
                    fault = LSU_ILLEGAL;
                else if (addr_lo[0])
                    fault = LSU_MISALIGN;
            end
            default: fault = LSU_ILLEGAL;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational load formatter: picks the byte/half addressed by offset out of
// the memory word and sign- or zero-extends it according to funct3.
module lsu_load_align
    import riscv_defines::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rdata[{offset, 3'b000} +: 8];
        sel_half = offset[1] ? rdata[31:16] : rdata[15:0];
        data     = '0;
        case (funct3)
            F3_B:    data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   data = {24'd0, sel_byte};
            F3_H:    data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   data = {16'd0, sel_half};
            F3_W:    data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of data_memory. Optional
// performance counters are built when LSU_PERF_CNT_EN is defined.
module load_store_unit
    import riscv_defines::*;
#(
    parameter int XLEN    = 32,
    parameter int WADDR_W = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_store,
    input  logic [2:0]         req_funct3,
    input  logic [XLEN-1:0]    req_addr,
    input  logic [XLEN-1:0]    req_wdata,
    output memaccess_t         memaccess,
    output logic [WADDR_W-1:0] word_addr,
    output logic [3:0]         wstrb,
    output logic [XLEN-1:0]    wdata,
    input  logic [XLEN-1:0]    rdata,
    input  logic               dmemfault,
    output logic               resp_valid,
    output logic [XLEN-1:0]    resp_data,
    output lsu_fault_t         resp_fault,
    output logic [31:0]        perf_loads,
    output logic [31:0]        perf_stores,
    output logic [31:0]        perf_faults
);

    lsu_state_t  state_reg, state_next;
    logic        store_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  offset_reg;
    lsu_fault_t  fault_reg;
    lsu_fault_t  check_fault;
    logic [3:0]  store_strb;
    logic [31:0] store_data;
    logic [31:0] load_data;

    assign req_ready   = (state_reg == IDLE);
    assign check_fault = lsu_check(req_store, req_funct3, req_addr[1:0]);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = (check_fault == LSU_OK) ? ISSUE : FAULT;
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = IDLE;
            FAULT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane steering for stores; loads drive no strobes and zero data.
    always_comb begin
        store_strb = 4'b0000;
        store_data = '0;
        if (req_store) begin
            case (req_funct3)
                F3_B: begin
                    store_strb = 4'b0001 << req_addr[1:0];
                    store_data = {4{req_wdata[7:0]}};
                end
                F3_H: begin
                    store_strb = 4'b0011 << req_addr[1:0];
                    store_data = {2{req_wdata[15:0]}};
                end
                default: begin
                    store_strb = 4'b1111;
                    store_data = req_wdata;
                end
            endcase
        end
    end

    lsu_load_align u_load_align (
        .rdata  (rdata),
        .funct3 (funct3_reg),
        .offset (offset_reg),
        .data   (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            store_reg  <= 1'b0;
            funct3_reg <= 3'b000;
            offset_reg <= 2'b00;
            fault_reg  <= LSU_OK;
            memaccess  <= MEM_DISABLED;
            word_addr  <= '0;
            wstrb      <= 4'b0000;
            wdata      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_fault <= LSU_OK;
        end else begin
            state_reg  <= state_next;
            resp_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        store_reg  <= req_store;
                        funct3_reg <= req_funct3;
                        offset_reg <= req_addr[1:0];
                        fault_reg  <= check_fault;
                        // Faulting requests never touch the memory port.
                        if (check_fault == LSU_OK) begin
                            memaccess <= req_store ? MEM_WRITE : MEM_READ;
                            word_addr <= req_addr[WADDR_W+1:2];
                            wstrb     <= store_strb;
                            wdata     <= store_data;
                        end
                    end
                end
                ISSUE: begin
                    memaccess <= MEM_DISABLED;
                    wstrb     <= 4'b0000;
                end
                WAIT: begin
                    resp_valid <= 1'b1;
                    if (dmemfault) begin
                        resp_fault <= LSU_ACCESS;
                        resp_data  <= '0;
                    end else begin
                        resp_fault <= LSU_OK;
                        resp_data  <= store_reg ? '0 : load_data;
                    end
                end
                FAULT: begin
                    resp_valid <= 1'b1;
                    resp_fault <= fault_reg;
                    resp_data  <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_loads_reg, perf_stores_reg, perf_faults_reg;
    logic        resp_edge;

    assign resp_edge = (state_reg == WAIT) || (state_reg == FAULT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_loads_reg  <= '0;
            perf_stores_reg <= '0;
            perf_faults_reg <= '0;
        end else if (resp_edge) begin
            if (store_reg)
                perf_stores_reg <= perf_stores_reg + 32'd1;
            else
                perf_loads_reg <= perf_loads_reg + 32'd1;
            if ((state_reg == FAULT) || dmemfault)
                perf_faults_reg <= perf_faults_reg + 32'd1;
        end
    end

    assign perf_loads  = perf_loads_reg;
    assign perf_stores = perf_stores_reg;
    assign perf_faults = perf_faults_reg;
`else
    assign perf_loads  = '0;
    assign perf_stores = '0;
    assign perf_faults = '0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural data_memory model
// (registered rdata/dmemfault, out-of-range word addresses fault).
module tb_load_store_unit;
    import riscv_defines::*;

    localparam int DMEM_WORD = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    memaccess_t  memaccess;
    logic [29:0] word_addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        dmemfault;
    logic        resp_valid;
    logic [31:0] resp_data;
    lsu_fault_t  resp_fault;
    logic [31:0] perf_loads, perf_stores, perf_faults;

    load_store_unit dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_store   (req_store),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .memaccess   (memaccess),
        .word_addr   (word_addr),
        .wstrb       (wstrb),
        .wdata       (wdata),
        .rdata       (rdata),
        .dmemfault   (dmemfault),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_fault  (resp_fault),
        .perf_loads  (perf_loads),
        .perf_stores (perf_stores),
        .perf_faults (perf_faults)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // data_memory model
    logic [31:0] mem [0:DMEM_WORD-1];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata     <= 32'd0;
            dmemfault <= 1'b0;
        end else begin
            dmemfault <= 1'b0;
            if (memaccess == MEM_READ) begin
                if (word_addr >= 30'(DMEM_WORD)) begin
                    dmemfault <= 1'b1;
                    rdata     <= 32'd0;
                end else begin
                    rdata <= mem[word_addr[7:0]];
                end
            end else if (memaccess == MEM_WRITE) begin
                if (word_addr >= 30'(DMEM_WORD))
                    dmemfault <= 1'b1;
                else
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) mem[word_addr[7:0]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic [31:0] data;
        lsu_fault_t  fault;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] shadow [0:DMEM_WORD-1];
    int          checks = 0;
    int          failures = 0;
    int          m_loads = 0, m_stores = 0, m_faults = 0;
    int          last_drive = 0;
    int          last_wait = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] load_model(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] off);
        logic [31:0] t;
        case (f3)
            3'b000: begin t = w << (24 - 8*off); return $unsigned($signed(t) >>> 24); end
            3'b100: begin t = w << (24 - 8*off); return t >> 24; end
            3'b001: begin t = w << (16 - 8*off); return $unsigned($signed(t) >>> 16); end
            3'b101: begin t = w << (16 - 8*off); return t >> 16; end
            default: return w;
        endcase
    endfunction

    // Waits for req_ready at a negedge, drives the request and pushes its expectation.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        int          n;
        logic        legal_f3, mis, oob;
        exp_t        e;
        logic [31:0] w;
        int          wi;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 20);
        if (!req_ready) begin
            check_val("ready_timeout", 32'd0, 32'd1);
            return;
        end
        last_wait = n - 1;
        legal_f3 = st ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                      : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
        oob = a[31:2] >= 30'(DMEM_WORD);
        e.data  = 32'd0;
        e.fault = LSU_OK;
        e.due   = cycle + 3;
        if (!legal_f3) begin
            e.fault = LSU_ILLEGAL;
            e.due   = cycle + 2;
        end else if (mis) begin
            e.fault = LSU_MISALIGN;
            e.due   = cycle + 2;
        end else if (oob) begin
            e.fault = LSU_ACCESS;
        end else begin
            wi = int'(a[9:2]);
            w  = shadow[wi];
            if (st) begin
                case (f3)
                    3'd0:    w[8*a[1:0] +: 8] = wd[7:0];
                    3'd1:    w[16*a[1] +: 16] = wd[15:0];
                    default: w = wd;
                endcase
                shadow[wi] = w;
            end else begin
                e.data = load_model(w, f3, a[1:0]);
            end
        end
        if (st) m_stores++; else m_loads++;
        if (e.fault != LSU_OK) m_faults++;
        last_drive = cycle;
        sb_q.push_back(e);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic release_req();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_perf(input int el, input int es, input int ef);
`ifdef LSU_PERF_CNT_EN
        check_val("perf_loads", perf_loads, 32'(el));
        check_val("perf_stores", perf_stores, 32'(es));
        check_val("perf_faults", perf_faults, 32'(ef));
`else
        check_val("perf_loads", perf_loads, 32'(el * 0));
        check_val("perf_stores", perf_stores, 32'(es * 0));
        check_val("perf_faults", perf_faults, 32'(ef * 0));
`endif
    endtask

    task automatic check_reset_outputs(input string phase);
        check_val({phase, "_ready"}, 32'(req_ready), 32'd1);
        check_val({phase, "_memaccess"}, 32'(memaccess), 32'(MEM_DISABLED));
        check_val({phase, "_word_addr"}, 32'(word_addr), 32'd0);
        check_val({phase, "_wstrb"}, 32'(wstrb), 32'd0);
        check_val({phase, "_wdata"}, wdata, 32'd0);
        check_val({phase, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check_val({phase, "_resp_data"}, resp_data, 32'd0);
        check_val({phase, "_resp_fault"}, 32'(resp_fault), 32'(LSU_OK));
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            $display("resp cycle=%0d data=%08h fault=%0d", cycle, resp_data, resp_fault);
            if (sb_q.size() == 0) begin
                check_val("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("resp_data", resp_data, mon_e.data);
                check_val("resp_fault", 32'(resp_fault), 32'(mon_e.fault));
                check_val("resp_cycle", 32'(cycle), 32'(mon_e.due));
            end
        end
    end

    initial begin
        int t0;
        for (int i = 0; i < DMEM_WORD; i++) begin
            mem[i]    = 32'd0;
            shadow[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check_perf(0, 0, 0);
        rst = 1'b0;

        // SB 0x13: lane 3 strobe, replicated byte
        issue(1'b1, 3'b000, 32'h13, 32'hA5);
        @(negedge clk);
        check_val("sb_memaccess", 32'(memaccess), 32'(MEM_WRITE));
        check_val("sb_word_addr", 32'(word_addr), 32'd4);
        check_val("sb_wstrb", 32'(wstrb), 32'b1000);
        check_val("sb_wdata", wdata, 32'hA5A5A5A5);
        check_val("sb_ready_low", 32'(req_ready), 32'd0);
        req_valid = 1'b0;

        issue(1'b1, 3'b010, 32'h20, 32'h80FF7F01);
        issue(1'b1, 3'b001, 32'h2E, 32'h1234BEEF);
        issue(1'b0, 3'b000, 32'h23, 32'h0);
        issue(1'b0, 3'b100, 32'h23, 32'h0);
        issue(1'b0, 3'b001, 32'h22, 32'h0);
        issue(1'b0, 3'b101, 32'h20, 32'h0);
        issue(1'b0, 3'b010, 32'h20, 32'h0);
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        issue(1'b0, 3'b101, 32'h2E, 32'h0);
        issue(1'b0, 3'b000, 32'h2F, 32'h0);
        release_req();
        drain();

        // misaligned LW: memory port must stay idle
        issue(1'b0, 3'b010, 32'h22, 32'h0);
        @(negedge clk);
        check_val("mis_memaccess0", 32'(memaccess), 32'(MEM_DISABLED));
        req_valid = 1'b0;
        @(negedge clk);
        check_val("mis_memaccess1", 32'(memaccess), 32'(MEM_DISABLED));
        issue(1'b0, 3'b011, 32'h20, 32'h0);
        issue(1'b0, 3'b011, 32'h21, 32'h0);
        issue(1'b1, 3'b100, 32'h20, 32'h0);
        issue(1'b1, 3'b001, 32'h21, 32'h0);
        issue(1'b0, 3'b001, 32'h23, 32'h0);
        issue(1'b0, 3'b010, 32'h400, 32'h0);
        issue(1'b1, 3'b010, 32'h800, 32'hDEADBEEF);
        release_req();
        drain();

        // back-to-back legal loads with req_valid held
        issue(1'b0, 3'b010, 32'h20, 32'h0);
        t0 = last_drive;
        issue(1'b0, 3'b000, 32'h21, 32'h0);
        check_val("b2b_wait1", 32'(last_wait), 32'd2);
        check_val("b2b_gap1", 32'(last_drive - t0), 32'd3);
        t0 = last_drive;
        issue(1'b0, 3'b100, 32'h22, 32'h0);
        check_val("b2b_wait2", 32'(last_wait), 32'd2);
        check_val("b2b_gap2", 32'(last_drive - t0), 32'd3);
        release_req();
        drain();
        check_perf(m_loads, m_stores, m_faults);

        // reset during WAIT drops the request
        issue(1'b0, 3'b010, 32'h20, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        sb_q.delete();
        m_loads  = 0;
        m_stores = 0;
        m_faults = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_perf(0, 0, 0);

        issue(1'b0, 3'b010, 32'h20, 32'h0);
        release_req();
        drain();
        check_perf(m_loads, m_stores, m_faults);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of data_memory.
- Accepts one load/store request at a time from the execute stage.
- Drives data_memory's memaccess, word_addr, wstrb and wdata.
- Consumes data_memory's registered rdata and dmemfault, then returns an aligned, sign/zero-extended load result with a fault code to writeback.
- Handles misalignment and illegal-size detection locally; misaligned or illegal requests never reach memory.

Parameters:
- XLEN, 32, data/address width (only 32 supported).
- WADDR_W, 30, word address width driven to data_memory.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (size/unsigned).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low-aligned.
- memaccess  out  memaccess_t  to data_memory.
- word_addr  out  30  to data_memory.
- wstrb  out  4  byte strobes to data_memory.
- wdata  out  32  lane-replicated store data.
- rdata  in  32  from data_memory, valid the cycle after it samples.
- dmemfault  in  1  from data_memory, same timing as rdata.
- resp_valid  out  1  one-cycle response pulse.
- resp_data  out  32  formatted load data; 0 for stores and faults.
- resp_fault  out  lsu_fault_t  fault code.
- perf_loads, perf_stores, perf_faults  out  32 each  counters (optional feature).

Behaviour:
- Reset values (async, immediate): state IDLE, memaccess MEM_DISABLED, word_addr 0, wstrb 0, wdata 0, resp_valid 0, resp_data 0, resp_fault LSU_OK, counters 0.
- Accept on the posedge where req_valid && req_ready. All request fields are registered at that edge; the upstream may change them afterwards.
- Legality check at accept:
  - Legal load funct3 values are 000, 001, 010, 100 and 101.
  - Legal store funct3 values are 000, 001 and 010.
  - Any other funct3 sets fault code LSU_ILLEGAL, which takes priority over misalignment.
  - A halfword with addr[0] set, or a word with addr[1:0] nonzero, sets fault code LSU_MISALIGN.
- State machine:
  - IDLE → ISSUE on accepting a legal request.
  - IDLE → FAULT on accepting an illegal or misaligned request.
  - ISSUE → WAIT unconditionally.
  - WAIT → IDLE.
  - FAULT → IDLE.
- ISSUE outputs (registered):
  - memaccess is MEM_READ or MEM_WRITE.
  - word_addr = addr[31:2].
  - Byte store: wstrb = 0001 shifted left by addr[1:0]; wdata = byte replicated 4 times.
  - Halfword store: wstrb = 0011 shifted left by addr[1:0]; wdata = half replicated 2 times.
  - Word store: wstrb = 1111; wdata = req_wdata.
  - Loads: wstrb 0000, wdata 0.
- WAIT: memaccess returns to MEM_DISABLED. At the WAIT→IDLE edge the response is registered:
  - If dmemfault: resp_fault = LSU_ACCESS, resp_data = 0.
  - Otherwise, for loads, the byte or half selected by addr[1:0] is sign-extended (LB, LH) or zero-extended (LBU, LHU); LW passes rdata through.
  - Stores: resp_data = 0.
  - resp_valid = 1 for exactly one cycle.
- FAULT: memory is never accessed. At the next edge: resp_valid = 1, resp_fault = the latched code, resp_data = 0.
- Latency:
  - Legal request: resp_valid is high in the cycle after the 3rd edge counted from acceptance (accept edge = edge 1).
  - Faulting request: response appears after the 2nd edge.
  - Back-to-back throughput: one request per 3 cycles (legal) or per 2 cycles (fault).
- Reset mid-operation: the in-flight request is dropped and no response is produced. A store already sampled by memory stays written.
- req_valid during a non-IDLE state is ignored; req_ready stays low.

Optional Feature:
- Macro LSU_PERF_CNT_EN.
- Defined: three 32-bit wrapping counters, incremented on the response edge:
  - perf_loads counts load responses.
  - perf_stores counts store responses.
  - perf_faults counts responses with resp_fault != LSU_OK.
- Undefined: the counter ports are tied to 0 and no counter flops are present.

Decomposition:
- riscv_defines package:
  - lsu_fault_t: 2-bit enum LSU_OK=0, LSU_MISALIGN=1, LSU_ACCESS=2, LSU_ILLEGAL=3.
  - lsu_state_t: IDLE, ISSUE, WAIT, FAULT.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - memaccess_t is reused unchanged.
- One natural sub-module: lsu_load_align, combinational rdata + funct3 + addr[1:0] → formatted data.

Test Plan:
- Store SB, addr 0x13, wdata 0xA5: in ISSUE, word_addr=4, wstrb=1000, wdata=0xA5A5A5A5. Response: resp_data=0, fault LSU_OK.
- After SW 0x80FF7F01 to addr 0x20:
  - LB addr 0x23 → 0xFFFFFF80.
  - LBU addr 0x23 → 0x00000080.
  - LH addr 0x22 → 0xFFFF80FF.
  - LHU addr 0x20 → 0x00007F01.
- LW addr 0x22: no memaccess ever leaves MEM_DISABLED; response after 2 edges with LSU_MISALIGN. Load funct3=011: LSU_ILLEGAL.
- LW to word address ≥ DMEM_WORD: memory asserts dmemfault; response has LSU_ACCESS, resp_data=0.
- req_valid held high with 3 legal loads: accepts spaced 3 cycles apart; req_ready low in ISSUE/WAIT; responses are in order.
- Assert rst during WAIT: all outputs return to reset values immediately and no resp_valid follows. With LSU_PERF_CNT_EN, counters read 0 afterwards and count correctly over the earlier scenarios.
